// File: rtl/score_display.sv
// Two-player score display: one-hot ball LEDs plus a 4-digit multiplexed 7-segment scoreboard.
// Optional macro LEADING_ZERO_BLANK_EN blanks a tens digit of 0.
module score_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] position,
    input  logic [3:0] score_player1,
    input  logic [3:0] score_player2,
    output logic [7:0] led,
    output logic [7:0] seg,
    output logic [3:0] dig_sel
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    idx;
    logic [3:0]    snap1, snap2;
    logic          phase;

    logic          scan_tc, blink_tc;
    logic [3:0]    sel_snap;
    logic          tens;
    logic [3:0]    digit;
    logic          blank;
    logic [7:0]    seg_nxt;
    logic [3:0]    dig_nxt;

    assign scan_tc  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign blink_tc = (blink_cnt == BW'(BLINK_DIV - 1));

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    // idx[1] selects the player (1 = player 1), idx[0] selects tens
    always_comb begin
        sel_snap = idx[1] ? snap1 : snap2;
        tens     = (sel_snap >= 4'd10);
        digit    = idx[0] ? {3'b000, tens} : (tens ? sel_snap - 4'd10 : sel_snap);
        blank    = (sel_snap == 4'd11) && !phase;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx[0] && !tens)
            blank = 1'b1;
`endif
        seg_nxt  = {(idx != 2'd2), (blank ? 7'h7F : enc(digit))};
        dig_nxt  = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led       <= 8'h00;
            seg       <= 8'hFF;
            dig_sel   <= 4'b1111;
            scan_cnt  <= '0;
            blink_cnt <= '0;
            idx       <= 2'd0;
            snap1     <= 4'd0;
            snap2     <= 4'd0;
            phase     <= 1'b1;
        end else begin
            led <= position;

            if (scan_tc) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
                // Snapshot only at frame start so a frame never mixes scores
                if (idx == 2'd3) begin
                    snap1 <= score_player1;
                    snap2 <= score_player2;
                end
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            if (blink_tc) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            // Both registered from the same idx so segments and enable stay aligned
            seg     <= seg_nxt;
            dig_sel <= dig_nxt;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with SCAN_DIV=2, BLINK_DIV=8 (one frame = one blink half-period).
module tb_score_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] position;
    logic [3:0] score_player1, score_player2;
    logic [7:0] led, seg;
    logic [3:0] dig_sel;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] ZT = 8'hFF;
`else
    localparam logic [7:0] ZT = 8'hC0;
`endif

    score_display #(.SCAN_DIV(2), .BLINK_DIV(8)) dut (
        .clk(clk), .rst(rst), .position(position),
        .score_player1(score_player1), .score_player2(score_player2),
        .led(led), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_dig(input logic [3:0] d);
        int n;
        n = 0;
        while (dig_sel !== d && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (dig_sel !== d) chk("wait_dig_timeout", dig_sel, d);
    endtask

    task automatic get_frame(output logic [7:0] s0, s1, s2, s3);
        wait_dig(4'b1110); s0 = seg;
        wait_dig(4'b1101); s1 = seg;
        wait_dig(4'b1011); s2 = seg;
        wait_dig(4'b0111); s3 = seg;
    endtask

    logic [3:0] dig_exp [9] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011,
                                4'b1011, 4'b0111, 4'b0111, 4'b1110};
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic       vis;

    initial begin
        rst = 1'b0; position = 8'hA5; score_player1 = 4'd9; score_player2 = 4'd9;
        repeat (3) @(negedge clk);
        chk("rst_led", led, 8'h00);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_dig", dig_sel, 4'b1111);

        position = 8'h00;
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("scan_dig%0d", i), dig_sel, dig_exp[i]);
            if (i == 0) chk("first_seg_snap0", seg, 8'hC0);
        end

        // scores 7 / 10
        score_player1 = 4'd7; score_player2 = 4'd10;
        wait_dig(4'b1101);
        get_frame(a0, a1, a2, a3);
        chk("s7_10_d0", a0, 8'hC0);
        chk("s7_10_d1", a1, 8'hF9);
        chk("s7_10_d2", a2, 8'h78);
        chk("s7_10_d3", a3, ZT);

        // 12..15 display plainly in both blink phases
        score_player1 = 4'd15; score_player2 = 4'd12;
        wait_dig(4'b1101);
        get_frame(a0, a1, a2, a3);
        get_frame(b0, b1, b2, b3);
        chk("s15_12_d0", a0, 8'hA4);
        chk("s15_12_d1", a1, 8'hF9);
        chk("s15_12_d2", a2, 8'h12);
        chk("s15_12_d3", a3, 8'hF9);
        chk("s15_12_d0_nb", b0, 8'hA4);
        chk("s15_12_d2_nb", b2, 8'h12);

        // mid-frame change is held off until the next wrap
        score_player1 = 4'd3; score_player2 = 4'd0;
        wait_dig(4'b1101);
        get_frame(a0, a1, a2, a3);
        chk("hold_pre", a2, 8'h30);
        wait_dig(4'b1101);
        score_player1 = 4'd4;
        wait_dig(4'b1011);
        chk("hold_old", seg, 8'h30);
        wait_dig(4'b1110);
        wait_dig(4'b1011);
        chk("hold_new", seg, 8'h19);

        // led tracks position one clock later
        @(negedge clk);
        position = 8'h80;
        #1 chk("led_no_lead", led, 8'h00);
        @(negedge clk); chk("led_80", led, 8'h80); position = 8'h40;
        @(negedge clk); chk("led_40", led, 8'h40); position = 8'h20;
        @(negedge clk); chk("led_20", led, 8'h20); position = 8'h00;
        @(negedge clk); chk("led_00", led, 8'h00);

        // player 2 at 11 blinks, player 1 steady
        score_player1 = 4'd5; score_player2 = 4'd11;
        wait_dig(4'b1101);
        get_frame(a0, a1, a2, a3);
        get_frame(b0, b1, b2, b3);
        vis = (a0 == 8'hF9);
        chk("blink_a0_legal", (a0 == 8'hF9) || (a0 == 8'hFF), 1);
        chk("blink_a1", a1, vis ? 8'hF9 : 8'hFF);
        chk("blink_b0", b0, vis ? 8'hFF : 8'hF9);
        chk("blink_b1", b1, vis ? 8'hFF : 8'hF9);
        chk("blink_p1_a2", a2, 8'h12);
        chk("blink_p1_b2", b2, 8'h12);
        chk("blink_p1_a3", a3, ZT);
        chk("blink_p1_b3", b3, ZT);

        // both at 11 blink, dp stays low on digit 2
        score_player1 = 4'd11; score_player2 = 4'd11;
        wait_dig(4'b1101);
        get_frame(a0, a1, a2, a3);
        get_frame(b0, b1, b2, b3);
        vis = (a2 == 8'h79);
        chk("both_a2_legal", (a2 == 8'h79) || (a2 == 8'h7F), 1);
        chk("both_a0", a0, vis ? 8'hF9 : 8'hFF);
        chk("both_a3", a3, vis ? 8'hF9 : 8'hFF);
        chk("both_b2", b2, vis ? 8'h7F : 8'h79);
        chk("both_b1", b1, vis ? 8'hFF : 8'hF9);

        // asynchronous reset mid-blink
        score_player1 = 4'd3; score_player2 = 4'd11;
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_led", led, 8'h00);
        chk("arst_seg", seg, 8'hFF);
        chk("arst_dig", dig_sel, 4'b1111);
        repeat (2) @(negedge clk);
        chk("arst_hold_dig", dig_sel, 4'b1111);
        rst = 1'b1;
        get_frame(a0, a1, a2, a3);
        chk("post_f0_d0", a0, 8'hC0);
        chk("post_f0_d1", a1, ZT);
        get_frame(b0, b1, b2, b3);
        chk("post_f1_d0_blank", b0, 8'hFF);
        chk("post_f1_d2", b2, 8'h30);
        get_frame(a0, a1, a2, a3);
        chk("post_f2_d0_vis", a0, 8'hF9);
        chk("post_f2_d1_vis", a1, 8'hF9);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
